conv_window_ctrl: RTL and testbench
===================================

CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 8: input image width in pixels, 3..255.
REQ-002 SHALL have parameter IMG_H, default 8: input image height in pixels, 3..255.
REQ-003 SHALL have parameter K, default 3: square kernel size and line-buffer depth.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-006 SHALL have port start  input  1  single-cycle request to begin one convolution pass.
REQ-007 SHALL have port stride  input  2  window stride; 1 and 2 legal, 0 and 3 illegal.
REQ-008 SHALL have port win_ready  input  1  downstream MAC accepts the current window.
REQ-009 SHALL have port shift_buffer  output  1  advance the line buffer by one pixel this cycle.
REQ-010 SHALL have port win_valid  output  1  line buffer currently holds a window to be computed.
REQ-011 SHALL have ports out_row and out_col  output  8 each  output-map coordinates of the current window.
REQ-012 SHALL have port busy  output  1  pass in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse at pass completion.
REQ-014 SHALL have port stride_err  output  1  one-cycle pulse when start arrives with an illegal stride.

Function
REQ-015 SHALL implement the states IDLE, RUN and FIN.
REQ-016 In IDLE, start=1 with a legal stride SHALL latch stride, clear the pixel row/col counters, and enter RUN on the next edge.
REQ-017 In IDLE, start=1 with stride 0 or 3 SHALL pulse stride_err on the next cycle and remain in IDLE.
REQ-018 start while in RUN or FIN SHALL be ignored; the stride input SHALL be ignored outside IDLE.
REQ-019 shift_buffer SHALL equal: state==RUN, AND pixels remaining, AND NOT (win_valid AND NOT win_ready); it is the only combinational path from an input (win_ready).
REQ-020 Each shift_buffer cycle SHALL advance the pixel counter col 0..IMG_W-1, wrapping to 0 and incrementing row.
REQ-021 A shift of pixel (row,col) SHALL set win_valid on the next cycle when all of the following hold: row>=K-1, col>=K-1, (row-K+1) mod stride==0, and (col-K+1) mod stride==0.
REQ-022 When win_valid is set, out_row SHALL be (row-K+1)/stride and out_col SHALL be (col-K+1)/stride, both registered with win_valid.
REQ-023 win_valid SHALL hold, with stable coordinates, until win_valid AND win_ready; it SHALL clear on the following cycle unless a new qualifying shift sets it again.
REQ-024 After the IMG_W*IMG_H-th shift, the FSM SHALL enter FIN once no window is pending.
REQ-025 FIN SHALL pulse done for exactly one cycle, then return to IDLE.
REQ-026 busy SHALL be 1 in RUN and FIN and 0 in IDLE.
REQ-027 The windows per pass SHALL be ((IMG_W-K)/stride+1)*((IMG_H-K)/stride+1), using integer division.
REQ-028 With win_ready held at 1, a pass SHALL take exactly IMG_W*IMG_H shift cycles.

Reset
REQ-029 rst=0 at any edge, including mid-pass, SHALL force IDLE and clear the counters and the latched stride.
REQ-030 During and after reset, every output SHALL be 0 (shift_buffer, win_valid, out_row, out_col, busy, done, stride_err).
REQ-031 An in-flight window SHALL be dropped on reset without handshake.

Configuration
REQ-032 When CONV_CTRL_PERF_EN is defined, the module SHALL add output stall_cnt (16 bits), counting cycles with win_valid AND NOT win_ready.
REQ-033 stall_cnt SHALL clear on entry to RUN, saturate at 16'hFFFF, and hold its value in IDLE.
REQ-034 When CONV_CTRL_PERF_EN is not defined, neither the port nor the counter SHALL exist; all other behaviour SHALL be identical.

Structure
REQ-035 Package conv_pkg SHALL hold the state encoding, the stride encodings (STRIDE_1=1, STRIDE_2=2), and the default K.
REQ-036 Sub-module conv_pos_cnt SHALL be the sole sub-module: a row/col pixel counter with wrap and an advance enable.

Verification
REQ-037 Scenario: IMG 8x8, stride=1, win_ready=1 -> 36 windows; out_row/out_col sweep 0..5; done pulses once; 64 shift_buffer cycles.
REQ-038 Scenario: stride=2, win_ready=1 -> 9 windows, coordinates (0..2,0..2), 64 shifts, done pulses once.
REQ-039 Scenario: win_ready=0 for 5 cycles on the first window -> shift_buffer=0 and coordinates (0,0) stable for those 5 cycles; resumes after the handshake; stall_cnt=5 when CONV_CTRL_PERF_EN is defined.
REQ-040 Scenario: start with stride=3 -> stride_err pulses one cycle, busy stays 0, no shifts.
REQ-041 Scenario: rst=0 after 20 shifts -> next cycle all outputs 0 and state IDLE; a new start then produces a full 36-window pass.
REQ-042 Scenario: start pulsed again during RUN, and stride changed mid-pass -> the pass is unaffected and the window count matches the latched stride.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution window controller.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam logic [1:0] STRIDE_1  = 2'd1;
  localparam logic [1:0] STRIDE_2  = 2'd2;
  localparam int         K_DEFAULT = 3;

  function automatic logic stride_legal(input logic [1:0] s);
    return (s == STRIDE_1) || (s == STRIDE_2);
  endfunction

endpackage

// File: rtl/conv_window_ctrl_if.sv
// Control/handshake bundle between a sequencer (master) and the window controller (slave).
interface conv_window_ctrl_if;
  logic       start;
  logic [1:0] stride;
  logic       win_ready;
  logic       shift_buffer;
  logic       win_valid;
  logic [7:0] out_row;
  logic [7:0] out_col;
  logic       busy;
  logic       done;
  logic       stride_err;

  modport master (
    output start, stride, win_ready,
    input  shift_buffer, win_valid, out_row, out_col, busy, done, stride_err
  );

  modport slave (
    input  start, stride, win_ready,
    output shift_buffer, win_valid, out_row, out_col, busy, done, stride_err
  );
endinterface

// File: rtl/conv_pos_cnt.sv
// Row/col pixel position counter: col wraps at IMG_W and carries into row.
module conv_pos_cnt #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       adv,
  output logic [7:0] row,
  output logic [7:0] col,
  output logic       last
);

  localparam logic [7:0] COL_MAX = 8'(IMG_W - 1);
  localparam logic [7:0] ROW_MAX = 8'(IMG_H - 1);

  // Position register: clear on a new pass, step on each advance.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      row <= '0;
      col <= '0;
    end else if (adv) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? 8'd0 : row + 8'd1;
      end else begin
        col <= col + 8'd1;
      end
    end
  end

  // Current position is the final pixel of the image.
  always_comb last = (row == ROW_MAX) && (col == COL_MAX);

endmodule

// File: rtl/conv_window_ctrl.sv
// Convolution window controller: sequences line-buffer shifts and presents
// output-map window coordinates to a downstream MAC with a valid/ready handshake.
// Optional build macro CONV_CTRL_PERF_EN adds a saturating stall counter port.
module conv_window_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int K     = K_DEFAULT
) (
  input logic clk,
  input logic rst,
  conv_window_ctrl_if.slave bus
`ifdef CONV_CTRL_PERF_EN
  , output logic [15:0] stall_cnt
`endif
);

  localparam logic [7:0] KM1 = 8'(K - 1);

  state_t     state, state_nxt;
  logic [1:0] stride_q;
  logic       all_shifted;
  logic       win_valid_q;
  logic [7:0] out_row_q, out_col_q;
  logic       stride_err_q;
  logic [7:0] row, col;
  logic       last;
  logic       start_ok;
  logic       shift;
  logic       busy_c, done_c;
  logic [7:0] row_off, col_off;
  logic       qual;

  assign start_ok = (state == ST_IDLE) && bus.start && stride_legal(bus.stride);

  conv_pos_cnt #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_pos (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_ok),
    .adv  (shift),
    .row  (row),
    .col  (col),
    .last (last)
  );

  // Window qualification for the pixel being shifted in this cycle.
  always_comb begin
    row_off = row - KM1;
    col_off = col - KM1;
    qual    = shift && (row >= KM1) && (col >= KM1) &&
              ((stride_q == STRIDE_1) || (!row_off[0] && !col_off[0]));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic: leave RUN only when all pixels are in and no window is pending.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_ok) state_nxt = ST_RUN;
      ST_RUN:  if (all_shifted && !win_valid_q) state_nxt = ST_FIN;
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs; shift is the only path combinational from an input (win_ready).
  always_comb begin
    shift  = (state == ST_RUN) && !all_shifted && !(win_valid_q && !bus.win_ready);
    busy_c = (state != ST_IDLE);
    done_c = (state == ST_FIN);
  end

  // Pass bookkeeping, window register and illegal-stride pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stride_q     <= '0;
      all_shifted  <= 1'b0;
      win_valid_q  <= 1'b0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      stride_err_q <= 1'b0;
    end else begin
      stride_err_q <= (state == ST_IDLE) && bus.start && !stride_legal(bus.stride);
      if (start_ok) begin
        stride_q    <= bus.stride;
        all_shifted <= 1'b0;
      end else if (shift && last) begin
        all_shifted <= 1'b1;
      end
      // A shift can only occur when the held window is being accepted, so a
      // new qualifying shift simply replaces it.
      if (qual) begin
        win_valid_q <= 1'b1;
        out_row_q   <= (stride_q == STRIDE_2) ? {1'b0, row_off[7:1]} : row_off;
        out_col_q   <= (stride_q == STRIDE_2) ? {1'b0, col_off[7:1]} : col_off;
      end else if (win_valid_q && bus.win_ready) begin
        win_valid_q <= 1'b0;
      end
    end
  end

`ifdef CONV_CTRL_PERF_EN
  // Saturating count of cycles the MAC back-pressures a valid window.
  always_ff @(posedge clk) begin
    if (!rst || start_ok) begin
      stall_cnt <= '0;
    end else if ((state != ST_IDLE) && win_valid_q && !bus.win_ready &&
                 (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

  assign bus.shift_buffer = shift;
  assign bus.win_valid    = win_valid_q;
  assign bus.out_row      = out_row_q;
  assign bus.out_col      = out_col_q;
  assign bus.busy         = busy_c;
  assign bus.done         = done_c;
  assign bus.stride_err   = stride_err_q;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Self-checking bench for conv_window_ctrl with an arithmetic window reference.
module tb_conv_window_ctrl;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int KK = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_window_ctrl_if bus ();
`ifdef CONV_CTRL_PERF_EN
  logic [15:0] stall_cnt;
`endif

  conv_window_ctrl #(.IMG_W(W), .IMG_H(H), .K(KK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CONV_CTRL_PERF_EN
    , .stall_cnt (stall_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_shift"}, int'(bus.shift_buffer), 0);
    check({tag, "_valid"}, int'(bus.win_valid), 0);
    check({tag, "_row"}, int'(bus.out_row), 0);
    check({tag, "_col"}, int'(bus.out_col), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
    check({tag, "_serr"}, int'(bus.stride_err), 0);
  endtask

  // Reference: every output coordinate in raster order for the given stride.
  task automatic build_expected(input int s, output int count);
    exp_q.delete();
    for (int r = 0; r <= (H - KK) / s; r++)
      for (int c = 0; c <= (W - KK) / s; c++)
        exp_q.push_back(r * 256 + c);
    count = ((W - KK) / s + 1) * ((H - KK) / s + 1);
  endtask

  task automatic stride_err_case(input int s);
    bus.stride = 2'(s);
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    check("serr_pulse", int'(bus.stride_err), 1);
    check("serr_busy", int'(bus.busy), 0);
    check("serr_shift", int'(bus.shift_buffer), 0);
    @(negedge clk);
    #1;
    check("serr_clear", int'(bus.stride_err), 0);
    check("serr_busy2", int'(bus.busy), 0);
  endtask

  // mode 0: ready held 1; 1: random ready; 2: first window stalled 5 cycles;
  // 3: start re-pulsed and stride changed mid-pass.
  task automatic run_pass(input int s, input int mode);
    int count, shifts, wins, dones, stalls, stall_left;
    int prev_stall, prev_r, prev_c, e;
    bit finished;
    build_expected(s, count);
    shifts = 0; wins = 0; dones = 0; stalls = 0; stall_left = 5;
    prev_stall = 0; prev_r = 0; prev_c = 0; finished = 0;
    bus.stride    = 2'(s);
    bus.win_ready = 1'b1;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      if (mode == 3 && cyc == 10) begin
        bus.start  = 1'b1;
        bus.stride = (s == 1) ? 2'd2 : 2'd1;
      end
      if (mode == 3 && cyc == 11) bus.start = 1'b0;
      case (mode)
        1: bus.win_ready = ($urandom_range(0, 3) != 0);
        2: if (bus.win_valid && stall_left > 0) begin
             bus.win_ready = 1'b0;
             stall_left--;
           end else bus.win_ready = 1'b1;
        default: bus.win_ready = 1'b1;
      endcase
      #1;
      if (prev_stall != 0) begin
        check("hold_valid", int'(bus.win_valid), 1);
        check("hold_row", int'(bus.out_row), prev_r);
        check("hold_col", int'(bus.out_col), prev_c);
      end
      if (bus.win_valid && !bus.win_ready) begin
        stalls++;
        check("stall_noshift", int'(bus.shift_buffer), 0);
        if (mode == 2) begin
          check("stall_row0", int'(bus.out_row), 0);
          check("stall_col0", int'(bus.out_col), 0);
        end
      end
      prev_stall = int'(bus.win_valid && !bus.win_ready);
      prev_r = int'(bus.out_row);
      prev_c = int'(bus.out_col);
      if (bus.shift_buffer) shifts++;
      if (bus.win_valid && bus.win_ready) begin
        wins++;
        if (exp_q.size() == 0) check("extra_window", wins, count);
        else begin
          e = exp_q.pop_front();
          check("win_row", int'(bus.out_row), e / 256);
          check("win_col", int'(bus.out_col), e % 256);
        end
      end
      if (bus.done) begin
        dones++;
        finished = 1;
      end
      @(negedge clk);
    end
    check("pass_done", dones, 1);
    check("pass_shifts", shifts, W * H);
    check("pass_windows", wins, count);
    check("pass_left", exp_q.size(), 0);
    #1;
    check("post_busy", int'(bus.busy), 0);
    check("post_done", int'(bus.done), 0);
    if (mode == 2) check("stall_cycles", stalls, 5);
`ifdef CONV_CTRL_PERF_EN
    check("stall_cnt", int'(stall_cnt), stalls);
`endif
  endtask

  initial begin
    int shifts;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.stride = 2'd0;
    bus.win_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
`ifdef CONV_CTRL_PERF_EN
    check("reset_stall_cnt", int'(stall_cnt), 0);
`endif
    rst = 1'b1;
    @(negedge clk);

    stride_err_case(3);
    stride_err_case(0);
    run_pass(1, 0);
    run_pass(2, 0);
    run_pass(1, 2);
    run_pass(2, 1);
    run_pass(1, 1);
    run_pass(1, 3);
    run_pass(2, 3);

    // Reset in the middle of a pass, then a clean pass.
    shifts = 0;
    bus.stride = 2'd1;
    bus.win_ready = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int cyc = 0; cyc < 200 && shifts < 20; cyc++) begin
      #1;
      if (bus.shift_buffer) shifts++;
      @(negedge clk);
    end
    check("pre_reset_shifts", shifts, 20);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_all_zero("midrst");
`ifdef CONV_CTRL_PERF_EN
    check("midrst_stall_cnt", int'(stall_cnt), 0);
`endif
    rst = 1'b1;
    @(negedge clk);
    run_pass(1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
